// File: rtl/oldland_memstage.sv
// oldland_memstage
//   Memory-access stage behind execute. Runs the data-bus handshake for
//   loads and stores, and the start/done handshake for cache maintenance.
//   It places store data on the correct byte lanes and zero-extends load data.
//   It produces the registered writeback and a one-cycle data_abort.
//   While busy is high, execute holds every request input stable.
// Ports
//   clk, rst                     clock, synchronous active-high reset
//   mem_load/mem_store/mem_width request kind and access width
//   mar, mdr                     byte address, store data (low bits)
//   wr_val, wr_result, rd_sel    non-memory result and destination
//   i_valid, pc_plus_4           instruction valid and its pc+4
//   cache_instr, cache_op        cache maintenance request
//   d_*                          data bus (address/lanes/data/strobe/request, ack/error/read data)
//   dc_start/dc_op/dc_done       cache-op handshake
//   busy, data_abort             stall and fault pulse back to execute
//   mwb_*, i_valid_out, pc_plus_4_out  registered writeback / retire
module oldland_memstage #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_load,
    input  logic        mem_store,
    input  logic [1:0]  mem_width,
    input  logic [31:0] mar,
    input  logic [31:0] mdr,
    input  logic [31:0] wr_val,
    input  logic        wr_result,
    input  logic [3:0]  rd_sel,
    input  logic        i_valid,
    input  logic [31:0] pc_plus_4,
    input  logic        cache_instr,
    input  logic [1:0]  cache_op,
    output logic [31:0] d_addr,
    output logic [3:0]  d_bytesel,
    output logic [31:0] d_wr_val,
    output logic        d_wr_en,
    output logic        d_access,
    input  logic        d_ack,
    input  logic        d_error,
    input  logic [31:0] d_data,
    output logic        dc_start,
    output logic [1:0]  dc_op,
    input  logic        dc_done,
    output logic        busy,
    output logic        data_abort,
    output logic [31:0] mwb_val,
    output logic        mwb_en,
    output logic [3:0]  mwb_rd_sel,
    output logic        i_valid_out,
    output logic [31:0] pc_plus_4_out
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT_ACK, S_WAIT_CACHE} state_t;

    // With TIMEOUT_CYCLES == 0 this wraps to all-ones, but the timeout is gated off anyway.
    localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYCLES) - 32'd1;
    localparam bit          TO_EN   = (TIMEOUT_CYCLES != 0);

    state_t      state;
    logic [31:0] count;

    logic is_byte, is_half, is_word;
    logic req, misaligned, term, timeout, cache_req, completing, fault;
    logic in_idle, in_wait_ack, in_wait_cache;
    logic [31:0] shifted, load_data;

    assign is_byte = (mem_width == 2'b00);
    assign is_half = (mem_width == 2'b01);
    assign is_word = mem_width[1];

    assign in_idle       = (state == S_IDLE);
    assign in_wait_ack   = (state == S_WAIT_ACK);
    assign in_wait_cache = (state == S_WAIT_CACHE);

    assign req        = i_valid & (mem_load | mem_store);
    assign misaligned = (is_half & mar[0]) | (is_word & |mar[1:0]);
    assign term       = d_ack | d_error;
    assign cache_req  = in_idle & i_valid & cache_instr;

    assign d_access = (in_idle & req & ~misaligned) | in_wait_ack;
    assign d_wr_en  = d_access & mem_store;
    assign d_addr   = {mar[31:2], 2'b00};
    assign dc_op    = cache_op;

    assign timeout = TO_EN & in_wait_ack & (count == TO_LAST) & ~term;

    assign busy = (d_access & ~term & ~timeout) | cache_req | (in_wait_cache & ~dc_done);

    // Execute holds i_valid through a stall, so retiring is just "valid and not stalled".
    assign completing = i_valid & ~busy;
    // A simultaneous ack and error counts as an error.
    assign fault      = (in_idle & req & misaligned) | (d_access & d_error) | timeout;

    // Little-endian lanes: byte k occupies bits [8k+7:8k].
    always_comb begin
        d_bytesel = 4'b1111;
        d_wr_val  = mdr;
        if (is_byte) begin
            d_bytesel = 4'b0001 << mar[1:0];
            d_wr_val  = {4{mdr[7:0]}};
        end else if (is_half) begin
            d_bytesel = mar[1] ? 4'b1100 : 4'b0011;
            d_wr_val  = {2{mdr[15:0]}};
        end
    end

    assign shifted = d_data >> {mar[1:0], 3'b000};

    always_comb begin
        load_data = d_data;
        if (is_byte)
            load_data = {24'b0, shifted[7:0]};
        else if (is_half)
            load_data = {16'b0, shifted[15:0]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            count         <= '0;
            dc_start      <= 1'b0;
            data_abort    <= 1'b0;
            mwb_val       <= '0;
            mwb_en        <= 1'b0;
            mwb_rd_sel    <= '0;
            i_valid_out   <= 1'b0;
            pc_plus_4_out <= '0;
        end else begin
            dc_start <= cache_req;

            unique case (state)
                S_IDLE: begin
                    if (cache_req)
                        state <= S_WAIT_CACHE;
                    else if (d_access & ~term)
                        state <= S_WAIT_ACK;
                end
                S_WAIT_ACK: begin
                    if (term | timeout)
                        state <= S_IDLE;
                end
                S_WAIT_CACHE: begin
                    if (dc_done)
                        state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase

            if (in_wait_ack & ~(term | timeout))
                count <= count + 32'd1;
            else
                count <= '0;

            // Retire. Stall cycles produce a bubble, and the faulting instruction never writes back.
            mwb_en      <= completing & wr_result & ~fault;
            i_valid_out <= completing;
            data_abort  <= completing & fault;
            if (completing) begin
                mwb_val       <= (mem_load & req) ? load_data : wr_val;
                mwb_rd_sel    <= rd_sel;
                pc_plus_4_out <= pc_plus_4;
            end
        end
    end

endmodule
